// File: rtl/cache_pkg.sv
// Types and defaults shared by the cache port arbiter and the CacheModel it fronts.
package cache_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int LAT_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;
endpackage

// File: rtl/cache_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick with a one-hot grant; the loser of the last tie wins the next one.
// Latency: grant is combinational from req; last_grant updates on the edge that takes a grant.
// Backpressure: none of its own; the caller pulses take only when it actually accepts.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);
    logic last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (take && (gnt != 2'b00)) begin
            last_grant <= gnt[1];
        end
    end
endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single-port CacheModel between two requesters and a report strobe.
// Latency: write rsp 2 cycles after accept, read rsp 1+RD_LAT cycles after accept.
// Backpressure: one transaction in flight; reqN_ready pulses only in IDLE for the granted side.
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    input  logic              report_req,
    output logic              report_ack,
    output logic              cache_write_en,
    output logic [ADDR_W-1:0] cache_address,
    output logic [DATA_W-1:0] cache_write_data,
    output logic              cache_report,
    input  logic [DATA_W-1:0] cache_read_data
);
    localparam logic [LAT_W-1:0] LAT_LAST = (RD_LAT >= 2) ? LAT_W'(RD_LAT - 2) : '0;

    state_t state, state_nxt;

    logic [1:0]        gnt;
    logic              arb_take;
    logic              rpt_go;
    logic              sample;
    logic              any_vld;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              wr_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic              rpt_last;
    logic              cwe_q;
    logic              rpt_q;
    logic [1:0]        rsp_q;

    assign any_vld   = req0_valid | req1_valid;
    assign sel_write = gnt[1] ? req1_write : req0_write;
    assign sel_addr  = gnt[1] ? req1_addr  : req0_addr;
    assign sel_wdata = gnt[1] ? req1_wdata : req0_wdata;

    rr_arbiter2 u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  ({req1_valid, req0_valid}),
        .take (arb_take),
        .gnt  (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        arb_take   = 1'b0;
        rpt_go     = 1'b0;
        sample     = 1'b0;
        case (state)
            ST_IDLE: begin
                // A report just issued yields one slot to any waiting requester.
                rpt_go = report_req && !(rpt_last && any_vld);
                if (rpt_go) begin
                    state_nxt = ST_REPORT;
                end else if (any_vld) begin
                    arb_take   = 1'b1;
                    req0_ready = gnt[0];
                    req1_ready = gnt[1];
                    state_nxt  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wr_q) begin
                    state_nxt = ST_DONE;
                end else if (RD_LAT <= 1) begin
                    sample    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    sample    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:   state_nxt = ST_IDLE;
            ST_REPORT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= 1'b0;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            lat_cnt  <= '0;
            rpt_last <= 1'b0;
            cwe_q    <= 1'b0;
            rpt_q    <= 1'b0;
            rsp_q    <= 2'b00;
        end else begin
            cwe_q <= arb_take && sel_write;
            rpt_q <= rpt_go;
            rsp_q <= {(state_nxt == ST_DONE) && owner_q, (state_nxt == ST_DONE) && !owner_q};
            if (arb_take) begin
                owner_q <= gnt[1];
                wr_q    <= sel_write;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                rdata_q <= '0;
            end
            if (sample) begin
                rdata_q <= cache_read_data;
            end
            if (state == ST_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end else begin
                lat_cnt <= '0;
            end
            if (rpt_go) begin
                rpt_last <= 1'b1;
            end else if (arb_take) begin
                rpt_last <= 1'b0;
            end
        end
    end

    assign cache_write_en   = cwe_q;
    assign cache_address    = addr_q;
    assign cache_write_data = wdata_q;
    assign cache_report     = rpt_q;
    assign report_ack       = rpt_q;
    assign rsp0_valid       = rsp_q[0];
    assign rsp1_valid       = rsp_q[1];
    assign rsp0_rdata       = rsp_q[0] ? rdata_q : '0;
    assign rsp1_rdata       = rsp_q[1] ? rdata_q : '0;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench: instance 0 runs with RD_LAT=1, instance 1 with RD_LAT=3, each behind a small cache model.
module tb_cache_port_arbiter;
    logic clk;
    logic rst;

    logic        r0v [2], r0w [2], r1v [2], r1w [2], rpt [2];
    logic [7:0]  r0a [2], r1a [2];
    logic [31:0] r0d [2], r1d [2];

    logic        rdy0 [2], rdy1 [2], rv0 [2], rv1 [2], ack [2], cwe [2], crep [2];
    logic [31:0] rd0 [2], rd1 [2], cwd [2], crd [2];
    logic [7:0]  caddr [2];

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v[0]), .req0_write(r0w[0]), .req0_addr(r0a[0]), .req0_wdata(r0d[0]),
        .req0_ready(rdy0[0]), .rsp0_valid(rv0[0]), .rsp0_rdata(rd0[0]),
        .req1_valid(r1v[0]), .req1_write(r1w[0]), .req1_addr(r1a[0]), .req1_wdata(r1d[0]),
        .req1_ready(rdy1[0]), .rsp1_valid(rv1[0]), .rsp1_rdata(rd1[0]),
        .report_req(rpt[0]), .report_ack(ack[0]),
        .cache_write_en(cwe[0]), .cache_address(caddr[0]), .cache_write_data(cwd[0]),
        .cache_report(crep[0]), .cache_read_data(crd[0])
    );

    cache_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v[1]), .req0_write(r0w[1]), .req0_addr(r0a[1]), .req0_wdata(r0d[1]),
        .req0_ready(rdy0[1]), .rsp0_valid(rv0[1]), .rsp0_rdata(rd0[1]),
        .req1_valid(r1v[1]), .req1_write(r1w[1]), .req1_addr(r1a[1]), .req1_wdata(r1d[1]),
        .req1_ready(rdy1[1]), .rsp1_valid(rv1[1]), .rsp1_rdata(rd1[1]),
        .report_req(rpt[1]), .report_ack(ack[1]),
        .cache_write_en(cwe[1]), .cache_address(caddr[1]), .cache_write_data(cwd[1]),
        .cache_report(crep[1]), .cache_read_data(crd[1])
    );

    // Cache models: instance 0 reads combinationally, instance 1 through two extra register stages.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        logic [31:0] mem [256];
        logic [31:0] p0, p1;
        always @(posedge clk) begin
            if (cwe[g]) mem[caddr[g]] <= cwd[g];
            p0 <= mem[caddr[g]];
            p1 <= p0;
        end
        assign crd[g] = (g == 0) ? mem[caddr[g]] : p1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctl(input int i);
        return {rdy0[i], rdy1[i], rv0[i], rv1[i], ack[i], cwe[i], crep[i]};
    endfunction

    task automatic set_req(input int idx, input int port, input logic v, input logic w,
                           input logic [7:0] a, input logic [31:0] d);
        if (port == 0) begin
            r0v[idx] = v; r0w[idx] = w; r0a[idx] = a; r0d[idx] = d;
        end else begin
            r1v[idx] = v; r1w[idx] = w; r1a[idx] = a; r1d[idx] = d;
        end
    endtask

    // One transaction from idle: immediate ready, exact response cycle, single pulses.
    task automatic run_req(input int idx, input int port, input logic wr, input logic [7:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input int lat,
                           input string tag);
        int   rsp_at, pulses, we_cnt, wait_c;
        logic rdy;
        rsp_at = -1; pulses = 0; we_cnt = 0; wait_c = 0;
        @(negedge clk);
        set_req(idx, port, 1'b1, wr, a, d);
        #1;
        rdy = (port == 0) ? rdy0[idx] : rdy1[idx];
        while (!rdy && wait_c < 20) begin
            @(negedge clk); #1;
            rdy = (port == 0) ? rdy0[idx] : rdy1[idx];
            wait_c++;
        end
        chk({tag, "_rdy_delay"}, 64'(wait_c), 64'd0);
        @(posedge clk); #1;
        set_req(idx, port, 1'b0, ~wr, ~a, ~d);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk); #1;
            if (c == 1) chk({tag, "_cache_addr"}, 64'(caddr[idx]), 64'(a));
            if (cwe[idx]) begin
                we_cnt++;
                chk({tag, "_cache_wdata"}, 64'(cwd[idx]), 64'(d));
            end
            if ((port == 0) ? rv0[idx] : rv1[idx]) begin
                pulses++;
                if (rsp_at < 0) rsp_at = c;
                chk({tag, "_rdata"}, 64'((port == 0) ? rd0[idx] : rd1[idx]), 64'(exp_rd));
            end
        end
        chk({tag, "_rsp_cycle"}, 64'(rsp_at), 64'(wr ? 2 : 1 + lat));
        chk({tag, "_rsp_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_we_pulses"}, 64'(we_cnt), 64'(wr ? 1 : 0));
    endtask

    initial begin
        logic [6:0] act;
        int         ng, ne, pulses;
        logic       gseq [4];
        logic       eseq [4];
        logic       exp_alt [4];
        exp_alt = '{1'b0, 1'b1, 1'b0, 1'b1};
        errors = 0;
        checks = 0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_req(i, 0, 1'b0, 1'b0, 8'h00, 32'h0);
            set_req(i, 1, 1'b0, 1'b0, 8'h00, 32'h0);
            rpt[i] = 1'b0;
        end

        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ctl%0d", i), 64'(ctl(i)), 64'd0);
            chk($sformatf("rst_rdata%0d", i), {rd0[i], rd1[i]}, 64'd0);
            chk($sformatf("rst_cache%0d", i), 64'({caddr[i], cwd[i]}), 64'd0);
        end
        rst = 1'b0;
        act = '0;
        repeat (5) begin
            @(negedge clk); #1;
            act = act | ctl(0) | ctl(1);
        end
        chk("idle_quiet", 64'(act), 64'd0);

        run_req(0, 0, 1'b1, 8'h20, 32'h00abcdef, 32'h0, 1, "wr0_l1");
        run_req(0, 1, 1'b0, 8'h20, 32'h0, 32'h00abcdef, 1, "rd1_l1");

        // Tie: both held valid; last grant went to req1, so expect 0,1,0,1.
        @(posedge clk); #1;
        set_req(0, 0, 1'b1, 1'b1, 8'h40, 32'h40404040);
        set_req(0, 1, 1'b1, 1'b1, 8'h41, 32'h41414141);
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk); #1;
            if (rdy0[0] || rdy1[0]) begin
                chk("tie_one_ready", 64'(rdy0[0] & rdy1[0]), 64'd0);
                gseq[ng] = rdy1[0];
                ng++;
            end
        end
        @(posedge clk); #1;
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
        set_req(0, 1, 1'b0, 1'b0, 8'h00, 32'h0);
        chk("tie_grants", 64'(ng), 64'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("tie_grant%0d", k), 64'(gseq[k]), 64'(exp_alt[k]));
        repeat (6) @(negedge clk);

        // Report held with req0 held: report, req0, report, req0.
        @(posedge clk); #1;
        rpt[0] = 1'b1;
        set_req(0, 0, 1'b1, 1'b1, 8'h50, 32'h50505050);
        ne = 0;
        for (int c = 0; c < 60 && ne < 4; c++) begin
            @(negedge clk); #1;
            if (crep[0]) begin
                chk("rpt_ack", 64'(ack[0]), 64'd1);
                eseq[ne] = 1'b0;
                ne++;
            end else if (rdy0[0]) begin
                eseq[ne] = 1'b1;
                ne++;
            end
        end
        @(posedge clk); #1;
        rpt[0] = 1'b0;
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
        chk("rpt_events", 64'(ne), 64'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("rpt_event%0d", k), 64'(eseq[k]), 64'(exp_alt[k]));
        repeat (6) @(negedge clk);

        run_req(1, 0, 1'b1, 8'h20, 32'h00abcdef, 32'h0, 3, "wr20_l3");
        run_req(1, 0, 1'b1, 8'h24, 32'h12345678, 32'h0, 3, "wr24_l3");
        run_req(1, 1, 1'b0, 8'h20, 32'h0, 32'h00abcdef, 3, "rd1_l3");

        // Reset while instance 1 sits in WAIT on a read.
        @(negedge clk);
        set_req(1, 0, 1'b1, 1'b0, 8'h24, 32'h0);
        #1;
        chk("mr_rdy", 64'(rdy0[1]), 64'd1);
        @(posedge clk); #1;
        set_req(1, 0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_ctl", 64'(ctl(1)), 64'd0);
        chk("mr_addr", 64'(caddr[1]), 64'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (rv0[1] || rv1[1]) pulses++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (rv0[1] || rv1[1]) pulses++;
        end
        chk("mr_no_rsp", 64'(pulses), 64'd0);
        run_req(1, 0, 1'b0, 8'h24, 32'h0, 32'h12345678, 3, "rd0_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
